// File: rtl/tag_sched.sv
// tag_sched: shares NUM_COL column tag slots among NUM_REQ requesters.
// A round-robin arbiter picks a requester, the lowest free tag is allocated,
// and a one-cycle flush is issued to that column's tag buffer. Slot occupancy
// is tracked until the requester releases the tag.
// Optional feature: define TAG_SCHED_CNT_EN to add a saturating grant counter
// output (grant_cnt).
module tag_sched #(
  parameter  int NUM_COL = 4,
  parameter  int NUM_REQ = 4,
  localparam int TW      = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
  localparam int RW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               rel_valid,
  input  logic [TW-1:0]      rel_tag,
  output logic [NUM_REQ-1:0] gnt,
  output logic [TW-1:0]      gnt_tag,
  output logic               flush,
  output logic [NUM_COL-1:0] flush_vec,
  output logic [TW-1:0]      tag_out,
  output logic [NUM_COL-1:0] busy,
  output logic               full,
`ifdef TAG_SCHED_CNT_EN
  output logic [15:0]        grant_cnt,
`endif
  output logic               err
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [RW-1:0]      rr_ptr;
  logic [RW-1:0]      win_q;

  logic               alloc;
  logic               win_found;
  logic [RW-1:0]      win_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [TW-1:0]      free_tag;
  logic [NUM_COL-1:0] alloc_mask;
  logic [NUM_COL-1:0] rel_mask;
  logic               rel_hit;
  logic [NUM_COL-1:0] busy_nxt;

  // Saturating increment so the counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Round-robin winner search: first set req bit at or above rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_d     = '0;
    gnt_d     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_d     = RW'(idx);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_d[i] = (int'(win_d) == i);
    end
  end

  // Lowest free tag from the pre-edge busy vector, plus release decode.
  // Out-of-range release tags match no slot and therefore count as not busy.
  always_comb begin
    free_tag = '0;
    for (int i = NUM_COL - 1; i >= 0; i--) begin
      if (!busy[i]) free_tag = TW'(i);
    end
    rel_mask = '0;
    rel_hit  = 1'b0;
    for (int i = 0; i < NUM_COL; i++) begin
      if (rel_valid && (int'(rel_tag) == i) && busy[i]) begin
        rel_mask[i] = 1'b1;
        rel_hit     = 1'b1;
      end
    end
  end

  // Next-state logic: one allocation decision per IDLE visit, ISSUE lasts one cycle.
  always_comb begin
    state_d = state_q;
    alloc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found && !full) begin
          alloc   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Allocation and release both apply; the freed slot is never reused on the same edge.
  always_comb begin
    alloc_mask = '0;
    for (int i = 0; i < NUM_COL; i++) begin
      alloc_mask[i] = alloc && (int'(free_tag) == i);
    end
    busy_nxt = (busy & ~rel_mask) | alloc_mask;
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Registered outputs, occupancy, error flag and round-robin pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gnt       <= '0;
      gnt_tag   <= '0;
      flush     <= 1'b0;
      flush_vec <= '0;
      tag_out   <= '0;
      busy      <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
      rr_ptr    <= '0;
      win_q     <= '0;
    end else begin
      busy <= busy_nxt;
      full <= &busy_nxt;
      if (rel_valid && !rel_hit) err <= 1'b1;
      if (alloc) begin
        gnt       <= gnt_d;
        gnt_tag   <= free_tag;
        tag_out   <= free_tag;
        flush     <= 1'b1;
        flush_vec <= alloc_mask;
        win_q     <= win_d;
      end else begin
        gnt       <= '0;
        gnt_tag   <= '0;
        flush     <= 1'b0;
        flush_vec <= '0;
      end
      if (state_q == ISSUE) begin
        rr_ptr <= (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + RW'(1);
      end
    end
  end

`ifdef TAG_SCHED_CNT_EN
  // Count ISSUE cycles, saturating at the top.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 grant_cnt <= '0;
    else if (state_q == ISSUE) grant_cnt <= sat_inc16(grant_cnt);
  end
`endif

endmodule

// File: tb/tb_tag_sched.sv
// Directed testbench for tag_sched with hand-computed expected values.
module tb_tag_sched;

  localparam int NUM_COL = 4;
  localparam int NUM_REQ = 4;
  localparam int TW      = 2;

  logic               clk = 1'b0;
  logic               rstn;
  logic [NUM_REQ-1:0] req;
  logic               rel_valid;
  logic [TW-1:0]      rel_tag;
  logic [NUM_REQ-1:0] gnt;
  logic [TW-1:0]      gnt_tag;
  logic               flush;
  logic [NUM_COL-1:0] flush_vec;
  logic [TW-1:0]      tag_out;
  logic [NUM_COL-1:0] busy;
  logic               full;
  logic               err;
`ifdef TAG_SCHED_CNT_EN
  logic [15:0]        grant_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  tag_sched #(.NUM_COL(NUM_COL), .NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .rel_valid (rel_valid),
    .rel_tag   (rel_tag),
    .gnt       (gnt),
    .gnt_tag   (gnt_tag),
    .flush     (flush),
    .flush_vec (flush_vec),
    .tag_out   (tag_out),
    .busy      (busy),
    .full      (full),
`ifdef TAG_SCHED_CNT_EN
    .grant_cnt (grant_cnt),
`endif
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    req       = '0;
    rel_valid = 1'b0;
    rel_tag   = '0;
    rstn      = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_flush_vec", 32'(flush_vec), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_full", 32'(full), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_tag_out", 32'(tag_out), 32'h0);
`ifdef TAG_SCHED_CNT_EN
    check("rst_cnt", 32'(grant_cnt), 32'h0);
`endif
    rstn = 1'b1;

    // Single request, held through the grant cycle
    req = 4'b0100;
    tick();
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_gnt_tag", 32'(gnt_tag), 32'h0);
    check("single_flush", 32'(flush), 32'h1);
    check("single_flush_vec", 32'(flush_vec), 32'h1);
    check("single_busy", 32'(busy), 32'h1);
    tick();
    req = '0;
    check("single_gnt_off", 32'(gnt), 32'h0);
    check("single_flush_off", 32'(flush), 32'h0);

    // Round-robin with all requesters active and delayed releases
    do_reset();
    req = 4'b1111;
    begin
      int gi;
      int pend_at;
      logic [TW-1:0] pend_tag;
      gi = 0;
      pend_at = -1;
      pend_tag = '0;
      for (int c = 0; c < 20 && gi < 5; c++) begin
        tick();
        rel_valid = 1'b0;
        if (c == pend_at) begin
          rel_valid = 1'b1;
          rel_tag   = pend_tag;
        end
        if (gnt != '0) begin
          check("rr_gnt", 32'(gnt), 32'(1) << exp_order[gi]);
          gi++;
          pend_tag = gnt_tag;
          pend_at  = c + 2;
        end
      end
      check("rr_count", 32'(gi), 32'd5);
    end
    rel_valid = 1'b0;
    req = '0;

    // Fill all slots with no releases
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 8; i++) tick();
    check("full_flag", 32'(full), 32'h1);
    check("full_busy", 32'(busy), 32'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_no_gnt", 32'(gnt), 32'h0);
      check("full_no_flush", 32'(flush), 32'h0);
    end
    // Release tag 2 while a request is pending: no grant on that edge
    rel_valid = 1'b1;
    rel_tag   = 2'd2;
    tick();
    rel_valid = 1'b0;
    check("rel2_busy", 32'(busy), 32'hB);
    check("rel2_full", 32'(full), 32'h0);
    check("rel2_no_gnt", 32'(gnt), 32'h0);
    tick();
    check("rel2_gnt_tag", 32'(gnt_tag), 32'h2);
    check("rel2_gnt", 32'(gnt), 32'h1);
    check("rel2_flush_vec", 32'(flush_vec), 32'h4);
    check("rel2_full_again", 32'(full), 32'h1);
    tick();
    // Simultaneous release of tag 1 with request pending while full
    rel_valid = 1'b1;
    rel_tag   = 2'd1;
    tick();
    rel_valid = 1'b0;
    check("sim_no_gnt", 32'(gnt), 32'h0);
    check("sim_busy", 32'(busy), 32'hD);
    tick();
    check("sim_gnt_tag", 32'(gnt_tag), 32'h1);
    check("sim_gnt", 32'(gnt), 32'h2);
    check("sim_tag_out", 32'(tag_out), 32'h1);
    req = '0;
    tick();

    // Bad release of a tag that is not busy
    do_reset();
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    check("bad_pre_busy", 32'(busy), 32'h1);
    rel_valid = 1'b1;
    rel_tag   = 2'd3;
    tick();
    rel_valid = 1'b0;
    check("bad_busy", 32'(busy), 32'h1);
    check("bad_err", 32'(err), 32'h1);
    tick();
    tick();
    check("bad_err_sticky", 32'(err), 32'h1);

    // Reset asserted in the middle of a flush cycle
    req = 4'b0010;
    tick();
    req = '0;
    check("mid_flush", 32'(flush), 32'h1);
    check("mid_tag_out", 32'(tag_out), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rst_flush", 32'(flush), 32'h0);
    check("mid_rst_flush_vec", 32'(flush_vec), 32'h0);
    check("mid_rst_gnt_tag", 32'(gnt_tag), 32'h0);
    check("mid_rst_tag_out", 32'(tag_out), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_err", 32'(err), 32'h0);
`ifdef TAG_SCHED_CNT_EN
    check("mid_rst_cnt", 32'(grant_cnt), 32'h0);
`endif
    tick();
    rstn = 1'b1;
    tick();
    check("no_replay_gnt", 32'(gnt), 32'h0);
    check("no_replay_busy", 32'(busy), 32'h0);
    req = 4'b1000;
    tick();
    req = '0;
    check("post_rst_gnt", 32'(gnt), 32'h8);
    check("post_rst_gnt_tag", 32'(gnt_tag), 32'h0);
    tick();
`ifdef TAG_SCHED_CNT_EN
    check("post_rst_cnt", 32'(grant_cnt), 32'h1);
`endif
    check("post_rst_idle", 32'(gnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
